// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display controller.
// Holds glyph constants, the hex-to-glyph decoder, the leading-zero
// blanking helper, the BCD converter state enum and display sizing.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned GLYPH_W    = 8;
  localparam logic [31:0] DEC_MAX    = 32'd99_999_999;

  // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  // Hex digit to active-low segment pattern; dp always off
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Decode all digits, blanking zeros from the top down until the first
  // non-zero digit; the rightmost digit always shows.
  function automatic logic [NUM_DIGITS*GLYPH_W-1:0] digits_to_glyphs(
    input logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    input logic                          blank_lz
  );
    logic [NUM_DIGITS*GLYPH_W-1:0] g;
    logic                          lead;
    logic [DIGIT_W-1:0]            d;
    g    = '0;
    lead = blank_lz;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      d = digits[i*DIGIT_W +: DIGIT_W];
      if (lead && (i != 0) && (d == '0)) begin
        g[i*GLYPH_W +: GLYPH_W] = GLYPH_BLANK;
      end else begin
        lead = 1'b0;
        g[i*GLYPH_W +: GLYPH_W] = hex_glyph(d);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 8-digit BCD converter.
// Ports: clk, rst (sync, active-high), start (load bin and begin),
//        bin[31:0] value to convert, busy (high for the 32 shift cycles),
//        done (one-cycle pulse while bcd is valid), bcd[31:0] result.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd
);

  conv_state_t state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [63:0] sreg_q, sreg_d;

  // One double-dabble step: correct BCD nibbles >= 5, then shift left
  function automatic logic [63:0] dabble_step(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      if (t[32 + 4*i +: 4] >= 4'd5) begin
        t[32 + 4*i +: 4] = t[32 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[62:0], 1'b0};
  endfunction

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d    = {32'd0, bin};
          bit_cnt_d = 5'd0;
          state_d   = CONV;
        end
      end
      CONV: begin
        sreg_d    = dabble_step(sreg_q);
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 5'd0;
      sreg_q    <= 64'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      busy      <= (state_d == CONV);
      done      <= (state_d == DONE);
    end
  end

  assign bcd = sreg_q[63:32];

endmodule

// File: rtl/seg_display_ctrl.sv
// 8-digit multiplexed seven-segment display of a 32-bit word, hex or
// unsigned decimal, with a per-frame input snapshot.
// Ports: clk, rst (sync, active-high), data_i word to show,
//        dec_mode_i (1 = decimal), blank_lz_i (1 = blank leading zeros),
//        seg_o active-low {dp,g,f,e,d,c,b,a}, an_o active-low digit
//        enables (bit0 = rightmost), busy_o BCD conversion in progress.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        dec_mode_i,
  input  logic        blank_lz_i,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o,
  output logic        busy_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned BUF_W = NUM_DIGITS * GLYPH_W;

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic             frame_start;
  logic             load_d;
  logic             wrap_c;
  logic [31:0]      snap_data;
  logic             snap_dec;
  logic             snap_blank;
  logic [BUF_W-1:0] disp_buf;
  logic             conv_start_c;
  logic             conv_done;
  logic [31:0]      conv_bcd;

  assign wrap_c = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Conversion starts on the boundary itself so busy rises one cycle later
  assign conv_start_c = frame_start && dec_mode_i && (data_i <= DEC_MAX);

  // Digit scan counter; frame boundary flagged on the 7->0 wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      frame_start <= 1'b1;
    end else begin
      if (wrap_c) begin
        div_cnt <= '0;
        idx     <= idx + IDX_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      frame_start <= wrap_c && (idx == IDX_W'(NUM_DIGITS - 1));
    end
  end

  // Input snapshot, taken only at frame boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_data  <= 32'd0;
      snap_dec   <= 1'b0;
      snap_blank <= 1'b0;
      load_d     <= 1'b0;
    end else begin
      load_d <= frame_start;
      if (frame_start) begin
        snap_data  <= data_i;
        snap_dec   <= dec_mode_i;
        snap_blank <= blank_lz_i;
      end
    end
  end

  // Display buffer: whole-word writes only, so a frame never shows a mix
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_buf <= {NUM_DIGITS{GLYPH_BLANK}};
    end else if (load_d && !snap_dec) begin
      disp_buf <= digits_to_glyphs(snap_data, snap_blank);
    end else if (load_d && (snap_data > DEC_MAX)) begin
      disp_buf <= {NUM_DIGITS{GLYPH_DASH}};
    end else if (conv_done) begin
      disp_buf <= digits_to_glyphs(conv_bcd, snap_blank);
    end
  end

  // Registered digit drive
  always_ff @(posedge clk) begin
    if (rst) begin
      an_o  <= 8'hFF;
      seg_o <= 8'hFF;
    end else begin
      an_o  <= ~(8'd1 << idx);
      seg_o <= disp_buf[{idx, 3'b000} +: GLYPH_W];
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start_c),
    .bin   (data_i),
    .busy  (busy_o),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Downstream consumer of the CPU core's 32-bit I/O output word (data_to_io).
- Shows the word on the board's 8-digit multiplexed seven-segment display, in hex or unsigned decimal.
- Decimal mode uses a sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Input is snapshotted once per scan frame, so the display never tears while the CPU updates the word.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays enabled. Must be >= 40 so a conversion always completes within one digit slot.

Ports:
- clk  input  1  CPU clock (cpuclk domain)
- rst  input  1  synchronous, active-high reset
- data_i  input  32  word to display; connects to data_to_io
- dec_mode_i  input  1  0 = hex, 1 = unsigned decimal
- blank_lz_i  input  1  1 = blank leading zeros
- seg_o  output  8  segment drives, active-low, bit order {dp,g,f,e,d,c,b,a}
- an_o  output  8  digit enables, active-low; bit0 = rightmost (least significant) digit
- busy_o  output  1  high while a BCD conversion is running

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: seg_o = 8'hFF, an_o = 8'hFF, busy_o = 0, scan counter = 0, digit index = 0, display buffer = all blank, frame_start flag = 1.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1.
  - On wrap, digit index advances 0→1→…→7→0.
  - The transition 7→0, and the first cycle after reset, is a frame boundary.
- Output timing: an_o and seg_o are registered and update 1 cycle after the digit index changes.
  - an_o = ~(1 << idx).
  - seg_o = glyph of buf[idx].
  - dp is always off.
- Snapshot: at a frame boundary, data_i, dec_mode_i and blank_lz_i are captured into shadow registers. Inputs are ignored at all other times.
- Hex path: the 8 nibbles of the snapshot are written to buf 1 cycle after the boundary.
- Decimal path FSM: IDLE → CONV → DONE → IDLE.
  - IDLE: on a boundary with dec_mode = 1, load shift reg = {32'b0 BCD, snapshot}, set bit_cnt = 0, go to CONV, and assert busy_o next cycle.
  - CONV: each cycle, add 3 to every BCD nibble >= 5, then shift left by 1 bit. After 32 cycles, go to DONE. busy_o is high for exactly 32 cycles.
  - DONE: write the 8 BCD digits to buf in a single cycle, drop busy_o, return to IDLE.
  - buf keeps its old contents until DONE, so updates are atomic.
- Overflow: in decimal mode, a snapshot > 99_999_999 bypasses conversion and writes "dash" to all 8 digits. busy_o stays 0.
- Leading-zero blanking: applied when buf is written.
  - From digit 7 downward, zero digits are marked blank until the first non-zero digit.
  - Digit 0 is never blanked.
  - Blank glyph = 8'hFF.
- Glyphs (active-low): 0-F standard. Examples: 0 = C0, 1 = F9, 8 = 80, A = 88, D = A1. dash = BF, blank = FF.
- Mode change mid-frame takes effect only at the next boundary.
- Reset mid-conversion: FSM returns to IDLE and busy_o = 0 on the next cycle; all outputs go to their reset values.

Decomposition:
- Shared package seg_pkg holds:
  - glyph constants: GLYPH_DASH, GLYPH_BLANK;
  - the hex-to-glyph decode function;
  - the FSM state enum {IDLE, CONV, DONE};
  - NUM_DIGITS = 8 and DEC_MAX = 99_999_999.
- One sub-module: bin2bcd_seq.
  - Ports: clk, rst, start, bin[31:0], busy, done, bcd[31:0].
  - Contains the double-dabble FSM.
- The top level holds the scan counter, snapshot and buffer logic, and the output registers.

Test Plan (SCAN_DIV = 40 in sim):
1. Reset held 3 cycles → seg_o = FF, an_o = FF, busy_o = 0. After release, an_o = FE within 2 cycles.
2. Hex mode, data_i = 32'h1234ABCD → over one frame: digit0 seg = A1 (D), digit7 seg = F9 (1); an_o walks FE, FD, …, 7F at 40-cycle intervals.
3. Decimal mode, data_i = 12345678 → busy_o high for exactly 32 cycles starting 1 cycle after the boundary. Next frame: digit0 = 80 (8), digit7 = F9 (1).
4. Decimal mode, data_i = 100_000_000 → busy_o stays 0; every digit seg = BF.
5. blank_lz_i = 1, hex mode, data_i = 32'h000000A0 → digits 7..2 = FF, digit1 = 88, digit0 = C0. With data_i = 0, only digit0 shows C0.
6. data_i changed mid-frame → displayed value holds until the next boundary. rst asserted at conversion cycle 10 → busy_o = 0 and an_o = FF the next cycle.
